// File: rtl/z3_bus_arbiter.sv
// rtl/z3_bus_arbiter.sv - Zorro III bus-master arbiter for the on-board SCSI controller
//
// Purpose:
//   Requests the Zorro III bus on behalf of the SCSI controller, waits for
//   grant and a free bus, then hands ownership to the controller.
//   Ownership is held through locked sequences. After ownership ends, the
//   request is held off for a back-off period. If grant never arrives, the
//   request is abandoned after a timeout.
//
// Parameters:
//   GRANT_TIMEOUT   max cycles spent requesting before giving up (8-bit)
//   BACKOFF_CYCLES  cycles BR_n stays high after timeout/release (>=1)
//
// Ports:
//   CLK            board clock, rising-edge
//   IORST_n        asynchronous active-low reset
//   SBR            SCSI bus request (active-high, CLK domain)
//   LOCK           SCSI locked-sequence request (active-high, CLK domain)
//   BG_n           Zorro III bus grant (active-low, asynchronous)
//   FCS_n_s        synchronized FCS_n, high = no address phase
//   DTACK_n_s      synchronized DTACK_n, high = no data acknowledge
//   slave_busy     board slave state machine not idle
//   BR_n           Zorro III bus request (active-low)
//   SBG            grant to SCSI controller (active-high)
//   MASTER         board owns the bus, enables master-direction buffers
//   grant_timeout  one-cycle pulse when a request times out
//   state_o        current FSM state for debug

module z3_bus_arbiter #(
  parameter logic [7:0] GRANT_TIMEOUT  = 8'd255,
  parameter logic [7:0] BACKOFF_CYCLES = 8'd4
) (
  input  logic       CLK,
  input  logic       IORST_n,
  input  logic       SBR,
  input  logic       LOCK,
  input  logic       BG_n,
  input  logic       FCS_n_s,
  input  logic       DTACK_n_s,
  input  logic       slave_busy,
  output logic       BR_n,
  output logic       SBG,
  output logic       MASTER,
  output logic       grant_timeout,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_FREE = 3'd2,
    ST_OWN       = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_BACKOFF   = 3'd5
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_bg_meta;
  logic       r_bg_s;

  state_t     w_next;
  logic       w_cnt_clr;
  logic       w_timeout;
  logic       w_bus_free;

  assign w_bus_free = FCS_n_s & DTACK_n_s;
  assign state_o    = r_state;

  // BG_n comes straight off the backplane; reset to "not granted" so a
  // stale low level cannot look like a grant right after reset.
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      r_bg_meta <= 1'b1;
      r_bg_s    <= 1'b1;
    end else begin
      r_bg_meta <= BG_n;
      r_bg_s    <= r_bg_meta;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A busy slave cycle blocks new master requests.
        if (SBR && !slave_busy) begin
          w_next    = ST_REQ;
          w_cnt_clr = 1'b1;
        end
      end
      ST_REQ: begin
        if (!SBR) begin
          w_next = ST_IDLE;
        end else if (!r_bg_s) begin
          w_next = ST_WAIT_FREE;
        end else if (r_cnt == GRANT_TIMEOUT - 8'd1) begin
          w_next    = ST_BACKOFF;
          w_cnt_clr = 1'b1;
          w_timeout = 1'b1;
        end
      end
      ST_WAIT_FREE: begin
        if (!SBR) begin
          w_next = ST_IDLE;
        end else if (w_bus_free && !slave_busy) begin
          w_next = ST_OWN;
        end
      end
      ST_OWN: begin
        // Grant withdrawal does not preempt; only the controller ends tenure.
        if (!SBR && !LOCK) begin
          w_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Keep driving until the last cycle we started has drained.
        if (w_bus_free) begin
          w_next    = ST_BACKOFF;
          w_cnt_clr = 1'b1;
        end
      end
      ST_BACKOFF: begin
        if (r_cnt == BACKOFF_CYCLES - 8'd1) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change together with
  // state_o and never glitch.
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 8'd0;
      BR_n          <= 1'b1;
      SBG           <= 1'b0;
      MASTER        <= 1'b0;
      grant_timeout <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_cnt_clr) begin
        r_cnt <= 8'd0;
      end else if ((r_state == ST_REQ || r_state == ST_BACKOFF) && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end

      BR_n          <= !(w_next == ST_REQ || w_next == ST_WAIT_FREE);
      SBG           <= (w_next == ST_OWN);
      MASTER        <= (w_next == ST_OWN || w_next == ST_RELEASE);
      grant_timeout <= w_timeout;
    end
  end

endmodule

// File: tb/tb_z3_bus_arbiter.sv
// tb/tb_z3_bus_arbiter.sv - table-driven scoreboard bench for z3_bus_arbiter

module tb_z3_bus_arbiter;

  logic       CLK = 1'b0;
  logic       IORST_n = 1'b0;
  logic       SBR = 1'b0;
  logic       LOCK = 1'b0;
  logic       BG_n = 1'b1;
  logic       FCS_n_s = 1'b1;
  logic       DTACK_n_s = 1'b1;
  logic       slave_busy = 1'b0;
  logic       BR_n;
  logic       SBG;
  logic       MASTER;
  logic       grant_timeout;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  // Expected output word: {state[2:0], BR_n, SBG, MASTER, grant_timeout}
  localparam logic [6:0] O_IDLE  = {3'd0, 4'b1000};
  localparam logic [6:0] O_REQ   = {3'd1, 4'b0000};
  localparam logic [6:0] O_WAIT  = {3'd2, 4'b0000};
  localparam logic [6:0] O_OWN   = {3'd3, 4'b1110};
  localparam logic [6:0] O_REL   = {3'd4, 4'b1010};
  localparam logic [6:0] O_BO    = {3'd5, 4'b1000};
  localparam logic [6:0] O_BO_TO = {3'd5, 4'b1001};

  // Input word: {SBR, LOCK, BG_n, FCS_n_s, DTACK_n_s, slave_busy}
  typedef struct packed {
    logic [5:0] in;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] sb_q[$];

  always #5 CLK = ~CLK;

  z3_bus_arbiter #(
    .GRANT_TIMEOUT (8'd8),
    .BACKOFF_CYCLES(8'd4)
  ) dut (
    .CLK          (CLK),
    .IORST_n      (IORST_n),
    .SBR          (SBR),
    .LOCK         (LOCK),
    .BG_n         (BG_n),
    .FCS_n_s      (FCS_n_s),
    .DTACK_n_s    (DTACK_n_s),
    .slave_busy   (slave_busy),
    .BR_n         (BR_n),
    .SBG          (SBG),
    .MASTER       (MASTER),
    .grant_timeout(grant_timeout),
    .state_o      (state_o)
  );

  function automatic logic [6:0] outs();
    return {state_o, BR_n, SBG, MASTER, grant_timeout};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d BR_n=%b SBG=%b MASTER=%b to=%b, expected st=%0d BR_n=%b SBG=%b MASTER=%b to=%b",
               name, got[6:4], got[3], got[2], got[1], got[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive on the falling edge, record the expectation, compare just after
  // the next rising edge.
  task automatic apply(input logic [5:0] in, input logic [6:0] exp, input string name);
    @(negedge CLK);
    {SBR, LOCK, BG_n, FCS_n_s, DTACK_n_s, slave_busy} = in;
    sb_q.push_back(exp);
    @(posedge CLK);
    #1;
    check(name, outs(), sb_q.pop_front());
  endtask

  task automatic add(input logic [5:0] in, input logic [6:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    // Grant path, lock hold, busy release, back-off ignoring SBR.
    add(6'b101110, O_REQ);
    add(6'b101110, O_REQ);
    add(6'b101110, O_REQ);
    add(6'b100110, O_REQ);    // BG_n falls
    add(6'b100110, O_REQ);
    add(6'b100110, O_WAIT);   // synchronized grant seen
    add(6'b100100, O_WAIT);   // DTACK busy
    add(6'b100111, O_WAIT);   // slave busy
    add(6'b100110, O_OWN);
    add(6'b101110, O_OWN);    // grant withdrawn, no preempt
    for (int i = 0; i < 5; i++) add(6'b011110, O_OWN);  // locked
    add(6'b001010, O_REL);    // bus still busy
    add(6'b001010, O_REL);
    add(6'b001010, O_REL);
    add(6'b001110, O_BO);
    add(6'b101110, O_BO);     // SBR ignored in back-off
    add(6'b101110, O_BO);
    add(6'b101110, O_BO);
    add(6'b101110, O_IDLE);
    add(6'b101110, O_REQ);
    add(6'b001110, O_IDLE);

    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", outs(), O_IDLE);
    @(negedge CLK);
    IORST_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].in, tbl[i].exp, $sformatf("grant[%0d]", i));
    end

    // Timeout: 8 request cycles, pulse, 4 back-off, idle, request again.
    for (int i = 0; i < 14; i++) begin
      logic [6:0] e;
      if (i < 8)       e = O_REQ;
      else if (i == 8) e = O_BO_TO;
      else if (i < 12) e = O_BO;
      else if (i == 12) e = O_IDLE;
      else             e = O_REQ;
      apply(6'b101110, e, $sformatf("timeout[%0d]", i));
    end
    apply(6'b001110, O_IDLE, "timeout_drop");

    // Slave priority.
    for (int i = 0; i < 3; i++) apply(6'b101111, O_IDLE, $sformatf("slave_prio[%0d]", i));
    apply(6'b101110, O_REQ, "slave_prio_req");
    apply(6'b001110, O_IDLE, "slave_prio_drop");

    // Reset mid-tenure.
    apply(6'b101110, O_REQ, "rst_own_a");
    apply(6'b100110, O_REQ, "rst_own_b");
    apply(6'b100110, O_REQ, "rst_own_c");
    apply(6'b100110, O_WAIT, "rst_own_d");
    apply(6'b100110, O_OWN, "rst_own_e");
    @(posedge CLK);
    #3;
    IORST_n = 1'b0;
    #1;
    check("reset_in_own_async", outs(), O_IDLE);
    BG_n = 1'b1;
    SBR  = 1'b0;
    @(negedge CLK);
    IORST_n = 1'b1;
    apply(6'b001110, O_IDLE, "post_reset_idle");
    apply(6'b101110, O_REQ, "post_reset_req");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/z3_bus_arbiter.md
Z3_BUS_ARBITER -- requirements
Module: z3_bus_arbiter

Interface
REQ-001 Parameter GRANT_TIMEOUT, default 255, max CLK cycles spent in REQ waiting for bus grant (8-bit).
REQ-002 Parameter BACKOFF_CYCLES, default 4, CLK cycles BR_n is held deasserted after a timeout or release (8-bit, >=1).
REQ-003 CLK  in  1  board clock; all state changes on rising edge.
REQ-004 IORST_n  in  1  reset; asynchronous, active-low.
REQ-005 SBR  in  1  SCSI controller bus request, active-high, synchronous to CLK.
REQ-006 LOCK  in  1  SCSI controller locked-sequence request, active-high, synchronous to CLK.
REQ-007 BG_n  in  1  Zorro III bus grant, active-low, asynchronous.
REQ-008 FCS_n_s  in  1  synchronized Zorro FCS_n; high = no address phase in progress.
REQ-009 DTACK_n_s  in  1  synchronized DTACK_n; high = no data acknowledge in progress.
REQ-010 slave_busy  in  1  high while the board's slave state machine is not idle.
REQ-011 BR_n  out  1  Zorro III bus request, active-low.
REQ-012 SBG  out  1  grant to SCSI controller, active-high.
REQ-013 MASTER  out  1  board owns the bus; enables master-direction buffers.
REQ-014 grant_timeout  out  1  one-cycle pulse on grant timeout.
REQ-015 state_o  out  3  current state encoding, for debug.

Function
REQ-016 BG_n SHALL pass through a 2-flop synchronizer reset to 1; the FSM SHALL use only the synchronized value bg_s.
REQ-017 States SHALL be IDLE=0, REQ=1, WAIT_FREE=2, OWN=3, RELEASE=4, BACKOFF=5; codes 6-7 SHALL return to IDLE on the next edge.
REQ-018 bus_free SHALL equal FCS_n_s AND DTACK_n_s.
REQ-019 IDLE: BR_n=1, SBG=0, MASTER=0; when SBR=1 and slave_busy=0, go to REQ and clear the 8-bit counter.
REQ-020 IDLE with SBR=1 and slave_busy=1 SHALL stay in IDLE; slave cycles have priority over new master requests.
REQ-021 REQ: BR_n=0 and the counter increments each cycle.
REQ-022 REQ exit priority, highest first:
- SBR=0 -> IDLE.
- bg_s=0 -> WAIT_FREE.
- counter = GRANT_TIMEOUT-1 -> BACKOFF, with grant_timeout=1 for exactly that transition cycle.
REQ-023 WAIT_FREE: BR_n=0; when bus_free=1 and slave_busy=0, go to OWN; when SBR=0, go to IDLE.
REQ-024 OWN: BR_n=1, SBG=1, MASTER=1; SBG and MASTER SHALL be asserted no earlier than the first OWN cycle (registered outputs).
REQ-025 OWN SHALL persist while SBR=1 or LOCK=1; bg_s deasserting during OWN SHALL NOT preempt ownership.
REQ-026 OWN with SBR=0 and LOCK=0 -> RELEASE.
REQ-027 RELEASE: SBG=0, MASTER=1 until bus_free=1, then BACKOFF with counter cleared; MASTER deasserts on entry to BACKOFF.
REQ-028 BACKOFF: BR_n=1, SBG=0, MASTER=0; counter increments; at counter = BACKOFF_CYCLES-1 -> IDLE.
REQ-029 SBR reasserted during BACKOFF SHALL be ignored until IDLE is reached.
REQ-030 SBG and BR_n=0 SHALL never be asserted in the same cycle; MASTER=0 SHALL imply SBG=0.
REQ-031 Counter SHALL saturate at 255 and never wrap.

Reset
REQ-032 IORST_n low SHALL asynchronously force:
- state IDLE, counter 0, synchronizer flops 1;
- BR_n=1, SBG=0, MASTER=0, grant_timeout=0.
REQ-033 Reset during OWN or RELEASE SHALL drop MASTER and SBG immediately, without waiting for bus_free.
REQ-034 First request evaluation SHALL occur on the first CLK edge after IORST_n deassertion.

Verification
REQ-035 Grant path: SBR=1, slave_busy=0, BG_n low 3 cycles later, bus_free=1 -> BR_n low 1 cycle after SBR, WAIT_FREE 2 cycles after BG_n, SBG=MASTER=1 next cycle.
REQ-036 Timeout: SBR=1, BG_n held high, GRANT_TIMEOUT=8 -> BR_n low 8 cycles, grant_timeout pulses once, BR_n high 4 cycles, then REQ again.
REQ-037 Lock hold: in OWN, SBR->0 with LOCK=1 for 5 cycles, then LOCK->0 -> SBG stays 1 for those 5 cycles, then RELEASE.
REQ-038 Release with bus busy: SBR->0 while FCS_n_s=0 for 3 cycles -> SBG=0 immediately, MASTER=1 for 3 cycles, then 0; then BACKOFF for 4 cycles.
REQ-039 Slave priority: slave_busy=1 with SBR=1 -> BR_n stays 1 until slave_busy falls, then asserts the next cycle.
REQ-040 Reset in OWN: IORST_n pulsed low mid-tenure -> SBG, MASTER=0 and BR_n=1 asynchronously, state_o=0.
